// File: rtl/clk_freq_meter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : clk_freq_meter_pkg
// Purpose  : Shared types and constants for the clock frequency meter:
//            FSM state encoding and the window-counter width helper.
// Revision : 1.0 - initial release
// ============================================================================
package clk_freq_meter_pkg;

    // Measurement sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_GATE = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Default window length and the matching window-counter width
    localparam int C_DEF_GATE_CYCLES = 64;
    localparam int C_WIN_W           = $clog2(C_DEF_GATE_CYCLES);

    // Window counter width for an arbitrary window length; it only ever holds
    // GATE_CYCLES-1 down to 0, so $clog2(GATE_CYCLES) bits suffice (min 1).
    function automatic int win_width(input int gate_cycles);
        return (gate_cycles < 2) ? 1 : $clog2(gate_cycles);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_edge_detect.sv
`default_nettype none
// ============================================================================
// Module   : sync_edge_detect
// Purpose  : Multi-stage synchroniser for an asynchronous single-bit input,
//            followed by a one-cycle rising-edge pulse generator.
// Revision : 1.0 - initial release
// ============================================================================
module sync_edge_detect
    import clk_freq_meter_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_in,
    input  logic reset,
    input  logic d_async,
    output logic d_sync,
    output logic rise
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    // Shift the asynchronous input through the synchroniser and keep one
    // cycle of history of the synchronised value for edge detection.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], d_async};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign d_sync = r_sync[SYNC_STAGES-1];
    assign rise   = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/clk_freq_meter.sv
`default_nettype none
// ============================================================================
// Module   : clk_freq_meter
// Purpose  : Counts rising edges of an asynchronous slow signal over a fixed
//            window of GATE_CYCLES system clocks and reports the result with
//            a one-cycle valid strobe and a saturation flag.
// Revision : 1.0 - initial release
// ============================================================================
module clk_freq_meter
    import clk_freq_meter_pkg::*;
#(
    parameter int GATE_CYCLES = 64,
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             sig_in,
    input  logic             start,
    output logic             busy,
    output logic [CNT_W-1:0] count_out,
    output logic             count_valid,
    output logic             overflow
);

    localparam int               WIN_W      = win_width(GATE_CYCLES);
    localparam logic [WIN_W-1:0] C_WIN_LOAD = WIN_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_CNT_MAX  = '1;

    state_t             r_state;
    state_t             w_next_state;
    logic [WIN_W-1:0]   r_win;
    logic [CNT_W-1:0]   r_edges;
    logic               r_sat;
    logic               r_busy;
    logic [CNT_W-1:0]   r_count_out;
    logic               r_count_valid;
    logic               r_overflow;
    logic               w_sig_sync;
    logic               w_rise;
    logic               w_edge;

    sync_edge_detect #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge_detect (
        .clk_in  (clk_in),
        .reset   (reset),
        .d_async (sig_in),
        .d_sync  (w_sig_sync),
        .rise    (w_rise)
    );

    // A rise pulse always coincides with a high synchronised level; the
    // qualification keeps the counted event tied to the settled value.
    assign w_edge = w_rise & w_sig_sync;

    // State register
    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode: one ARM cycle, GATE until the window counter hits 0,
    // one DONE cycle, then back to IDLE. start is only looked at in IDLE.
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            ST_IDLE: if (start) w_next_state = ST_ARM;
            ST_ARM:  w_next_state = ST_GATE;
            ST_GATE: if (r_win == '0) w_next_state = ST_DONE;
            ST_DONE: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Datapath: window/edge counters, sticky saturation, result registers
    // and the registered busy decode.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_win         <= '0;
            r_edges       <= '0;
            r_sat         <= 1'b0;
            r_busy        <= 1'b0;
            r_count_out   <= '0;
            r_count_valid <= 1'b0;
            r_overflow    <= 1'b0;
        end else begin
            r_count_valid <= 1'b0;
            r_busy        <= (w_next_state == ST_ARM) || (w_next_state == ST_GATE);
            case (r_state)
                ST_ARM: begin
                    r_edges <= '0;
                    r_sat   <= 1'b0;
                    r_win   <= C_WIN_LOAD;
                end
                ST_GATE: begin
                    // An edge in the final window cycle is still counted.
                    if (w_edge) begin
                        if (r_edges == C_CNT_MAX) begin
                            r_sat <= 1'b1;
                        end else begin
                            r_edges <= r_edges + 1'b1;
                        end
                    end
                    if (r_win != '0) begin
                        r_win <= r_win - 1'b1;
                    end
                end
                ST_DONE: begin
                    // Result becomes visible in the first IDLE cycle.
                    r_count_out   <= r_edges;
                    r_overflow    <= r_sat;
                    r_count_valid <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign busy        = r_busy;
    assign count_out   = r_count_out;
    assign count_valid = r_count_valid;
    assign overflow    = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_clk_freq_meter.sv
`default_nettype none
// ============================================================================
// Module   : tb_clk_freq_meter
// Purpose  : Self-checking bench for clk_freq_meter. A 16-bit instance and a
//            4-bit (saturating) instance share the same stimulus; expected
//            results are queued at start and compared when count_valid fires.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clk_freq_meter;

    localparam int G = 64;

    typedef struct {
        logic [15:0] cnt;
        logic        ovf;
    } exp_t;

    logic        clk_in = 1'b0;
    logic        reset  = 1'b1;
    logic        sig_in = 1'b0;
    logic        start  = 1'b0;
    logic        busy;
    logic        count_valid;
    logic        overflow;
    logic [15:0] count_out;
    logic        s_busy;
    logic        s_valid;
    logic        s_ovf;
    logic [3:0]  s_count;

    int          checks    = 0;
    int          failures  = 0;
    int          n_valid   = 0;
    int          n_valid_s = 0;
    int          sig_mode  = 0;
    int          v0;
    int          vs0;
    logic [1:0]  ph = 2'd0;
    exp_t        q_main[$];
    exp_t        q_sat[$];
    exp_t        e_m;
    exp_t        e_s;

    clk_freq_meter #(.GATE_CYCLES(G), .CNT_W(16), .SYNC_STAGES(2)) dut (
        .clk_in      (clk_in),
        .reset       (reset),
        .sig_in      (sig_in),
        .start       (start),
        .busy        (busy),
        .count_out   (count_out),
        .count_valid (count_valid),
        .overflow    (overflow)
    );

    clk_freq_meter #(.GATE_CYCLES(G), .CNT_W(4), .SYNC_STAGES(2)) dut_sat (
        .clk_in      (clk_in),
        .reset       (reset),
        .sig_in      (sig_in),
        .start       (start),
        .busy        (s_busy),
        .count_out   (s_count),
        .count_valid (s_valid),
        .overflow    (s_ovf)
    );

    always #5 clk_in = ~clk_in;

    // Signal under measurement: 0 low, 1 high, 2 toggle (period 2), 3 div-by-4
    always @(negedge clk_in) begin
        ph = ph + 2'd1;
        case (sig_mode)
            0:       sig_in = 1'b0;
            1:       sig_in = 1'b1;
            2:       sig_in = ~sig_in;
            default: sig_in = ph[1];
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Scoreboard: every valid strobe pops one expected result per instance
    always @(posedge clk_in) begin
        #1;
        if (count_valid === 1'b1) begin
            n_valid++;
            chk("main_valid_expected", (q_main.size() > 0), 1);
            if (q_main.size() > 0) begin
                e_m = q_main.pop_front();
                chk("main_count", count_out, e_m.cnt);
                chk("main_overflow", overflow, e_m.ovf);
            end
        end
        if (s_valid === 1'b1) begin
            n_valid_s++;
            chk("sat_valid_expected", (q_sat.size() > 0), 1);
            if (q_sat.size() > 0) begin
                e_s = q_sat.pop_front();
                chk("sat_count", s_count, e_s.cnt);
                chk("sat_overflow", s_ovf, e_s.ovf);
            end
        end
    end

    task automatic push_expected(input int expn);
        exp_t e;
        e.cnt = 16'(expn);
        e.ovf = 1'b0;
        q_main.push_back(e);
        e.cnt = (expn > 15) ? 16'd15 : 16'(expn);
        e.ovf = (expn > 15);
        q_sat.push_back(e);
    endtask

    // One full measurement; optionally pokes start again mid-window.
    task automatic measure(input int mode, input int expn, input bit poke);
        int a0;
        int b0;
        sig_mode = mode;
        repeat (8) @(negedge clk_in);
        push_expected(expn);
        a0 = n_valid;
        b0 = n_valid_s;
        start = 1'b1;
        @(posedge clk_in); #1;
        chk("busy_arm", busy, 1);
        for (int k = 1; k <= G + 1; k++) begin
            @(negedge clk_in);
            start = (poke && k == 32);
            @(posedge clk_in); #1;
            chk("busy_window", busy, (k <= G));
            chk("sat_busy_window", s_busy, (k <= G));
            chk("valid_early", count_valid, 0);
        end
        @(posedge clk_in); #1;
        chk("valid_pulse", count_valid, 1);
        chk("sat_valid_pulse", s_valid, 1);
        chk("busy_after", busy, 0);
        repeat (G + 6) @(posedge clk_in);
        #1;
        chk("one_valid", n_valid - a0, 1);
        chk("sat_one_valid", n_valid_s - b0, 1);
        chk("valid_low_after", count_valid, 0);
    endtask

    initial begin
        // Reset and idle
        reset = 1'b1;
        repeat (3) @(posedge clk_in);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_count", count_out, 0);
        chk("rst_valid", count_valid, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_sat_count", s_count, 0);
        @(negedge clk_in);
        reset = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk_in); #1;
            chk("idle_busy", busy, 0);
            chk("idle_valid", count_valid, 0);
        end
        chk("idle_count", count_out, 0);
        chk("idle_overflow", overflow, 0);

        // Divide-by-4 with a redundant start during the window
        measure(3, 16, 1'b1);
        // Period-2 input: 32 edges (saturates the 4-bit instance)
        measure(2, 32, 1'b0);
        // Constant high: no edges, sticky saturation cleared
        measure(1, 0, 1'b0);
        // Divide-by-4 again so the result registers are non-zero
        measure(3, 16, 1'b0);

        // Reset in the middle of the window
        sig_mode = 3;
        repeat (8) @(negedge clk_in);
        v0  = n_valid;
        vs0 = n_valid_s;
        start = 1'b1;
        @(posedge clk_in);
        @(negedge clk_in);
        start = 1'b0;
        repeat (19) @(posedge clk_in);
        @(negedge clk_in);
        reset = 1'b1;
        @(posedge clk_in); #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_count", count_out, 0);
        chk("midrst_overflow", overflow, 0);
        chk("midrst_valid", count_valid, 0);
        chk("midrst_sat_count", s_count, 0);
        chk("midrst_sat_overflow", s_ovf, 0);
        @(negedge clk_in);
        reset = 1'b0;
        repeat (G + 10) @(posedge clk_in);
        #1;
        chk("midrst_no_valid", n_valid - v0, 0);
        chk("midrst_sat_no_valid", n_valid_s - vs0, 0);

        // Normal measurement after the aborted one
        measure(3, 16, 1'b0);

        chk("queue_drained", q_main.size() + q_sat.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
